apb_slave_mem: RTL

APB completer holding a byte-wide register file, sitting directly downstream of the APB requester on the shared PCLK/PRESETn bus. Two instances are used: one on the requester's sel1 for PADDR[8]=0, one on sel2 for PADDR[8]=1. Each instance decodes PADDR[7:0] and completes transfers after a parameterised number of wait states. It returns PRDATA and PREADY, and signals out-of-range accesses on PSLVERR.

---
 rtl/apb_pkg.sv | 7 +
 rtl/apb_slave_regfile.sv | 27 ++
 rtl/apb_slave_mem.sv | 69 ++++++
 3 files changed

// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM encoding and bus/index widths.
package apb_pkg;
  typedef enum logic {IDLE, ACCESS} state_t;
  localparam int APB_ADDR_W = 9;
  localparam int APB_DATA_W = 8;
  localparam int IDX_W      = 8;
endpackage

// File: rtl/apb_slave_regfile.sv
// DEPTH x DATA_W storage: one synchronous write port, one combinational read port.
module apb_slave_regfile
  import apb_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int DATA_W = APB_DATA_W
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0][DATA_W-1:0] mem;

  // Callers only raise we for in-range indices, so the low AW bits suffice.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn)  mem <= '0;
    else if (we)   mem[waddr[AW-1:0]] <= wdata;
  end

  assign rdata = (32'(raddr) < DEPTH) ? mem[raddr[AW-1:0]] : '0;
endmodule

// File: rtl/apb_slave_mem.sv
// APB completer over a byte register file with programmable wait states and
// PSLVERR on indices beyond DEPTH.
module apb_slave_mem
  import apb_pkg::*;
#(
  parameter int DATA_W      = APB_DATA_W,
  parameter int ADDR_W      = APB_ADDR_W,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [DATA_W-1:0] PWDATA,
  output logic              PREADY,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PSLVERR
);
  state_t            state;
  logic [3:0]        cnt;
  logic [IDX_W-1:0]  idx;
  logic              in_range;
  logic              we;
  logic [DATA_W-1:0] rdata;
  logic              unused_hi;

  // Upper address bits select between instances upstream via PSEL.
  assign unused_hi = ^PADDR[ADDR_W-1:IDX_W];
  assign idx       = PADDR[IDX_W-1:0];
  assign in_range  = (32'(idx) < DEPTH);

  assign PREADY  = (state == ACCESS) && PSEL && PENABLE && (cnt == 4'd0);
  assign PSLVERR = PREADY && !in_range;
  assign PRDATA  = (PREADY && !PWRITE && in_range) ? rdata : '0;
  assign we      = PREADY && PWRITE && in_range;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      case (state)
        IDLE: if (PSEL && !PENABLE) begin
          state <= ACCESS;
          cnt   <= 4'(WAIT_CYCLES);
        end
        ACCESS: begin
          // Dropping PSEL mid-access abandons the transfer without a write.
          if (!PSEL || PREADY)             state <= IDLE;
          else if (PENABLE && cnt != 4'd0) cnt   <= cnt - 4'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  apb_slave_regfile #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_rf (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .we      (we),
    .waddr   (idx),
    .wdata   (PWDATA),
    .raddr   (idx),
    .rdata   (rdata)
  );
endmodule
